// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - read-side controller for the async transmit byte FIFO
//
// Owns the read pointer, derives empty/occupancy from the synchronized Gray
// write count, and sequences packet reads for the transmit encoder.
//
// Ports:
//   r_clk, n_rst        read clock, asynchronous active-low reset
//   w_count_sync        Gray write count, already in the r_clk domain
//   pkt_req, pkt_len    packet request and its byte count (taken in IDLE)
//   get_byte            encoder pull, honoured in STREAM
//   flush               discard everything buffered, abort the packet
//   r_count             registered Gray read count for the write domain
//   r_addr, r_en        FIFO RAM read port
//   byte_valid          RAM data valid, one cycle after r_en
//   last_byte           marks the final byte of the packet
//   empty, occupancy    FIFO status
//   pkt_busy, pkt_done  packet sequencing status
//   err_underrun        pull arrived in STREAM with nothing buffered
module fifo_rd_ctrl #(
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 7
) (
    input  logic              r_clk,
    input  logic              n_rst,
    input  logic [ADDR_W:0]   w_count_sync,
    input  logic              pkt_req,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              get_byte,
    input  logic              flush,
    output logic [ADDR_W:0]   r_count,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_en,
    output logic              byte_valid,
    output logic              last_byte,
    output logic              empty,
    output logic [ADDR_W:0]   occupancy,
    output logic              pkt_busy,
    output logic              pkt_done,
    output logic              err_underrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    logic [1:0]       state_q, state_d;
    logic [ADDR_W:0]  rbin_q, rbin_d;
    logic [ADDR_W:0]  rgray_q, rgray_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             byte_valid_q, byte_valid_d;
    logic             last_byte_q, last_byte_d;
    logic             err_underrun_q, err_underrun_d;
    logic [ADDR_W:0]  wbin;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            wbin[i] = ^(w_count_sync >> i);
        end
    end

    assign occupancy = wbin - rbin_q;
    assign empty     = (rgray_q == w_count_sync);
    assign r_addr    = rbin_q[ADDR_W-1:0];
    assign r_count   = rgray_q;
    assign r_en      = (state_q == S_STREAM) && get_byte && !empty && !flush;

    assign byte_valid   = byte_valid_q;
    assign last_byte    = last_byte_q;
    assign err_underrun = err_underrun_q;
    assign pkt_busy     = (state_q == S_WAIT) || (state_q == S_STREAM);
    assign pkt_done     = (state_q == S_DONE);

    always_comb begin
        state_d        = state_q;
        rbin_d         = rbin_q;
        remaining_d    = remaining_q;
        byte_valid_d   = r_en;
        last_byte_d    = r_en && (remaining_q == LEN_ONE);
        err_underrun_d = (state_q == S_STREAM) && get_byte && empty && !flush;

        if (flush) begin
            // Jump the read pointer to the write pointer: everything buffered is dropped.
            state_d     = S_IDLE;
            rbin_d      = wbin;
            remaining_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pkt_req) begin
                        if (pkt_len != '0) begin
                            remaining_d = pkt_len;
                            state_d     = S_WAIT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    // Only start once the whole packet is buffered so streaming never stalls.
                    if (32'(occupancy) >= 32'(remaining_q)) begin
                        state_d = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (r_en) begin
                        rbin_d      = rbin_q + PTR_ONE;
                        remaining_d = remaining_q - LEN_ONE;
                        if (remaining_q == LEN_ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        rgray_d = rbin_d ^ (rbin_d >> 1);
    end

    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            rbin_q         <= '0;
            rgray_q        <= '0;
            remaining_q    <= '0;
            byte_valid_q   <= 1'b0;
            last_byte_q    <= 1'b0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rbin_q         <= rbin_d;
            rgray_q        <= rgray_d;
            remaining_q    <= remaining_d;
            byte_valid_q   <= byte_valid_d;
            last_byte_q    <= last_byte_d;
            err_underrun_q <= err_underrun_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - self-checking bench for fifo_rd_ctrl
module tb_fifo_rd_ctrl;

    logic       r_clk = 1'b0;
    logic       n_rst;
    logic [7:0] w_count_sync;
    logic       pkt_req;
    logic [6:0] pkt_len;
    logic       get_byte;
    logic       flush;
    logic [7:0] r_count;
    logic [6:0] r_addr;
    logic       r_en;
    logic       byte_valid;
    logic       last_byte;
    logic       empty;
    logic [7:0] occupancy;
    logic       pkt_busy;
    logic       pkt_done;
    logic       err_underrun;

    fifo_rd_ctrl #(.ADDR_W(7), .LEN_W(7)) dut (
        .r_clk        (r_clk),
        .n_rst        (n_rst),
        .w_count_sync (w_count_sync),
        .pkt_req      (pkt_req),
        .pkt_len      (pkt_len),
        .get_byte     (get_byte),
        .flush        (flush),
        .r_count      (r_count),
        .r_addr       (r_addr),
        .r_en         (r_en),
        .byte_valid   (byte_valid),
        .last_byte    (last_byte),
        .empty        (empty),
        .occupancy    (occupancy),
        .pkt_busy     (pkt_busy),
        .pkt_done     (pkt_done),
        .err_underrun (err_underrun)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [6:0] addr;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_rbin;
    int         m_rem;

    task automatic tick;
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] w);
        n_rst = 1'b0; w_count_sync = w; pkt_req = 1'b0; pkt_len = '0;
        get_byte = 1'b0; flush = 1'b0;
        tick; tick;
        n_rst = 1'b1;
        m_rbin = '0; m_rem = 0;
        exp_q.delete();
    endtask

    task automatic request(input logic [6:0] len);
        pkt_req = 1'b1; pkt_len = len;
        tick;
        pkt_req = 1'b0;
        m_rem = int'(len);
    endtask

    // One get_byte cycle; the expected read is queued when driven and popped when byte_valid appears.
    task automatic pull(input bit exp_rd);
        exp_t e;
        get_byte = 1'b1;
        #1;
        checks++;
        if (r_en !== exp_rd) begin errors++; $display("FAIL r_en: got %b want %b", r_en, exp_rd); end
        if (exp_rd) begin
            e.addr = m_rbin[6:0];
            e.last = (m_rem == 1);
            exp_q.push_back(e);
            checks++;
            if (r_addr !== e.addr) begin errors++; $display("FAIL r_addr: got %h want %h", r_addr, e.addr); end
            m_rbin = m_rbin + 8'd1;
            m_rem  = m_rem - 1;
        end
        tick;
        get_byte = 1'b0;
        checks++;
        if (byte_valid !== exp_rd) begin errors++; $display("FAIL byte_valid: got %b want %b", byte_valid, exp_rd); end
        if (byte_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (last_byte !== e.last) begin errors++; $display("FAIL last_byte: got %b want %b", last_byte, e.last); end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0; w_count_sync = 8'h00; pkt_req = 1'b0; pkt_len = '0;
        get_byte = 1'b0; flush = 1'b0;
        #1;
        checks++; if (r_count !== 8'h00) begin errors++; $display("FAIL rst_r_count: got %h want 00", r_count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (occupancy !== 8'h00) begin errors++; $display("FAIL rst_occupancy: got %h want 00", occupancy); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL rst_pkt_busy: got %b want 0", pkt_busy); end
        checks++;
        if ({byte_valid, last_byte, pkt_done, err_underrun, r_en} !== 5'b0) begin
            errors++;
            $display("FAIL rst_pulses: got %b want 00000", {byte_valid, last_byte, pkt_done, err_underrun, r_en});
        end
        do_reset(8'h00);
    endtask

    task automatic test_basic;
        do_reset(8'h00);
        w_count_sync = 8'h07;
        #1;
        checks++; if (occupancy !== 8'd5) begin errors++; $display("FAIL basic_occ: got %0d want 5", occupancy); end
        tick;
        request(7'd5);
        checks++; if (pkt_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", pkt_busy); end
        tick;
        for (int i = 0; i < 5; i++) pull(1'b1);
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", pkt_done); end
        tick;
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", pkt_done); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", pkt_busy); end
        checks++; if (r_count !== 8'h07) begin errors++; $display("FAIL basic_r_count: got %h want 07", r_count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", empty); end
    endtask

    task automatic test_wait;
        do_reset(8'h00);
        w_count_sync = 8'h03;
        tick;
        request(7'd4);
        for (int i = 0; i < 3; i++) begin
            pull(1'b0);
            checks++; if (pkt_busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", pkt_busy); end
            checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL wait_err: got %b want 0", err_underrun); end
        end
        w_count_sync = 8'h06;
        tick;
        for (int i = 0; i < 4; i++) pull(1'b1);
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL wait_done: got %b want 1", pkt_done); end
        tick;
    endtask

    task automatic test_wrap;
        do_reset(8'h00);
        w_count_sync = 8'h81;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        m_rbin = 8'd254;
        checks++; if (r_count !== 8'h81) begin errors++; $display("FAIL wrap_preload: got %h want 81", r_count); end
        w_count_sync = 8'h03;
        #1;
        checks++; if (occupancy !== 8'd4) begin errors++; $display("FAIL wrap_occ: got %0d want 4", occupancy); end
        tick;
        request(7'd4);
        tick;
        for (int i = 0; i < 4; i++) pull(1'b1);
        tick;
        checks++; if (r_count !== 8'h03) begin errors++; $display("FAIL wrap_r_count: got %h want 03", r_count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_flush;
        do_reset(8'h00);
        w_count_sync = 8'h07;
        tick;
        request(7'd5);
        tick;
        pull(1'b1);
        pull(1'b1);
        flush = 1'b1; get_byte = 1'b1;
        #1;
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL flush_r_en: got %b want 0", r_en); end
        tick;
        flush = 1'b0; get_byte = 1'b0;
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b want 0", pkt_busy); end
        checks++; if (r_count !== 8'h07) begin errors++; $display("FAIL flush_r_count: got %h want 07", r_count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", byte_valid); end
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", pkt_done); end
        tick;
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL flush_done_late: got %b want 0", pkt_done); end
        // A request coinciding with flush must be dropped.
        w_count_sync = 8'h04;
        pkt_req = 1'b1; pkt_len = 7'd2; flush = 1'b1;
        tick;
        pkt_req = 1'b0; flush = 1'b0;
        tick;
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL flush_req_drop: got %b want 0", pkt_busy); end
    endtask

    task automatic test_reset_mid;
        do_reset(8'h00);
        w_count_sync = 8'h07;
        tick;
        request(7'd5);
        tick;
        pull(1'b1);
        n_rst = 1'b0;
        #1;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", byte_valid); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", pkt_busy); end
        checks++; if (r_count !== 8'h00) begin errors++; $display("FAIL mid_r_count: got %h want 00", r_count); end
        checks++; if (occupancy !== 8'd5) begin errors++; $display("FAIL mid_occ: got %0d want 5", occupancy); end
        tick;
        n_rst = 1'b1;
        exp_q.delete();
        tick;
        checks++; if (r_count !== 8'h00) begin errors++; $display("FAIL mid_rel_r_count: got %h want 00", r_count); end
        checks++; if (pkt_busy !== 1'b0) begin errors++; $display("FAIL mid_rel_busy: got %b want 0", pkt_busy); end
        get_byte = 1'b1;
        request(7'd0);
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", pkt_done); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL zero_r_en: got %b want 0", r_en); end
        tick;
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", pkt_done); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL zero_r_en_idle: got %b want 0", r_en); end
        get_byte = 1'b0;
        tick;
        checks++; if (r_count !== 8'h00) begin errors++; $display("FAIL zero_r_count: got %h want 00", r_count); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait;
        test_wrap;
        test_flush;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller for the transmitter's asynchronous byte FIFO. It runs in the read clock domain and takes the synchronized Gray write count. It owns the read pointer and produces the empty flag and occupancy. It also sequences packet reads: on a request it waits until a whole packet is buffered, then streams bytes out of the FIFO RAM on demand from the transmit encoder.

Parameters:
ADDR_W, 7, FIFO RAM address width (depth 2^ADDR_W); pointers/counts are ADDR_W+1 bits
LEN_W, 7, packet length field width (max packet 2^LEN_W-1 bytes)

Ports:
r_clk  input  1  read-domain clock, rising edge
n_rst  input  1  asynchronous active-low reset
w_count_sync  input  ADDR_W+1  Gray-coded write count, already synchronized to r_clk
pkt_req  input  1  one-cycle request to send a packet; sampled only in IDLE
pkt_len  input  LEN_W  byte count for pkt_req, sampled with pkt_req
get_byte  input  1  encoder pulls next byte; honoured only in STREAM
flush  input  1  synchronous discard of all buffered data
r_count  output  ADDR_W+1  registered Gray read count, for synchronization into write domain
r_addr  output  ADDR_W  FIFO RAM read address
r_en  output  1  FIFO RAM read enable
byte_valid  output  1  RAM read data valid (one cycle after r_en)
last_byte  output  1  qualifies byte_valid for final byte of packet
empty  output  1  FIFO empty
occupancy  output  ADDR_W+1  bytes buffered
pkt_busy  output  1  high in WAIT and STREAM
pkt_done  output  1  one-cycle pulse on packet completion
err_underrun  output  1  one-cycle pulse when get_byte arrives in STREAM while empty

Behaviour:
- Reset: all registers 0. The FSM goes to IDLE. r_count=0, byte_valid=0, last_byte=0, pkt_done=0, err_underrun=0. empty follows its equation (1 if w_count_sync=0).
- Internal state: registered binary read pointer rbin, with Gray copy rgray updated on the same edge; r_count=rgray.
- wbin is the Gray-to-binary conversion of w_count_sync (combinational).
- occupancy = (wbin - rbin) mod 2^(ADDR_W+1), combinational.
- empty = (rgray == w_count_sync).
- r_addr = rbin[ADDR_W-1:0].
- FSM states IDLE, WAIT, STREAM, DONE.
- IDLE:
  - pkt_req with pkt_len!=0: latch remaining=pkt_len and go to WAIT.
  - pkt_req with pkt_len=0: go to DONE; no bytes are read.
- WAIT:
  - pkt_busy=1.
  - When occupancy >= remaining, go to STREAM on the next edge.
  - pkt_req is ignored.
- STREAM:
  - r_en = get_byte & ~empty, combinational, same cycle.
  - On r_en: rbin+1 and remaining-1 on the next edge. byte_valid=1 on the next cycle. last_byte=1 with it if remaining was 1.
  - When the decrement reaches 0, go to DONE.
  - get_byte while empty: no read, and err_underrun pulses next cycle.
- DONE: pkt_done=1 for exactly one cycle, then IDLE. A pkt_req in DONE is ignored.
- Wrap-around: rbin wraps modulo 2^(ADDR_W+1), and r_addr wraps modulo 2^ADDR_W with no special handling.
- flush (highest priority, any state):
  - Next edge: rbin<=wbin, rgray<=w_count_sync, FSM<=IDLE, remaining<=0, byte_valid<=0, last_byte<=0.
  - No pkt_done. r_en is forced 0 in the flush cycle.
- Simultaneous pkt_req and flush: flush wins and the request is dropped.
- Reset mid-operation aborts immediately; all outputs return to reset values asynchronously.
- Read pointer advance is bounded by occupancy, so the controller never reads past the write count.

Test Plan:
- Reset with w_count_sync=0x00 -> r_count=0x00, empty=1, occupancy=0, pkt_busy=0, and all pulses 0.
- w_count_sync=0x07 (5 bytes), then pkt_req with pkt_len=5, then 5 get_byte pulses -> r_addr 0x00..0x04 with r_en, byte_valid each following cycle, last_byte on the 5th, pkt_done one cycle later, then r_count=0x07 and empty=1.
- w_count_sync=0x03 (2 bytes) with pkt_req len 4 -> FSM holds WAIT, and get_byte is ignored (no r_en). When w_count_sync becomes 0x06 (4), STREAM is entered on the next cycle.
- Preload rbin=254 (r_count=0x81) with w_count_sync=0x03 (wbin 2) -> occupancy=4. A len-4 packet reads r_addr 0x7E, 0x7F, 0x00, 0x01 and ends with r_count=0x03 and empty=1.
- 5-byte packet, flush after 2 bytes are read -> next cycle IDLE, r_count=w_count_sync, empty=1, no pkt_done, and byte_valid=0.
- Assert n_rst=0 mid-STREAM -> outputs immediately take reset values. After release, IDLE with r_count=0x00; pkt_len=0 request -> pkt_done one pulse and no r_en.
